system_tester: RTL and testbench

SYSTEM_TESTER -- requirements
Module: system_tester

---
 rtl/system_tester_pkg.sv | 21 ++
 rtl/system_tester.sv | 128 ++++++++++++
 tb/tb_system_tester.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/system_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : system_tester_pkg
// Description : Shared state encoding and checker truth table for system_tester.
// Revision    : 1.0
// ============================================================================
package system_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit i is the expected dut_out when vector i = {v1,v2,v3} is applied.
  localparam logic [7:0] c_exp_table = 8'b0111_1111;
  localparam logic [2:0] c_last_vec  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/system_tester.sv
`default_nettype none
// ============================================================================
// Module      : system_tester
// Description : Walks all 8 input vectors of a 3-input NAND checker, counts mismatches.
// Revision    : 1.0
// ============================================================================
module system_tester
  import system_tester_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       v1,
  output logic       v2,
  output logic       v3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] vec_idx
);

  localparam logic [3:0] c_settle_last = 4'(SETTLE_CYC - 1);

  state_t     r_state, w_state;
  logic [2:0] r_vec, w_vec;
  logic [3:0] r_cnt, w_cnt;
  logic [3:0] r_err, w_err;
  logic       r_pass, w_pass;
  logic       r_done, w_done;
  logic       r_busy, w_busy;
  logic [2:0] r_v, w_v;
  logic       w_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_vec   <= 3'd0;
      r_cnt   <= 4'd0;
      r_err   <= 4'd0;
      r_pass  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_v     <= 3'd0;
    end else begin
      r_state <= w_state;
      r_vec   <= w_vec;
      r_cnt   <= w_cnt;
      r_err   <= w_err;
      r_pass  <= w_pass;
      r_done  <= w_done;
      r_busy  <= w_busy;
      r_v     <= w_v;
    end
  end

  // Every output is the registered copy of a next-state value, so dut_out
  // only ever reaches outputs through a flop.
  always_comb begin
    w_state = r_state;
    w_vec   = r_vec;
    w_cnt   = r_cnt;
    w_err   = r_err;
    w_pass  = r_pass;
    w_done  = 1'b0;
    w_busy  = r_busy;
    w_v     = r_v;
    w_mis   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        w_v    = 3'd0;
        if (start) begin
          w_state = ST_DRIVE;
          w_vec   = 3'd0;
          w_cnt   = 4'd0;
          w_err   = 4'd0;
          w_pass  = 1'b0;
          w_busy  = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == c_settle_last) begin
          w_state = ST_SAMPLE;
          w_cnt   = 4'd0;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      ST_SAMPLE: begin
        w_mis = (dut_out != c_exp_table[r_vec]);
        w_err = r_err + {3'd0, w_mis};
        if (r_vec == c_last_vec) begin
          w_state = ST_DONE;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_v     = 3'd0;
          w_pass  = (w_err == 4'd0);
        end else begin
          w_state = ST_DRIVE;
          w_vec   = r_vec + 3'd1;
          w_v     = r_vec + 3'd1;
          w_cnt   = 4'd0;
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign v1      = r_v[2];
  assign v2      = r_v[1];
  assign v3      = r_v[0];
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err;
  assign vec_idx = r_vec;

endmodule
`default_nettype wire

// File: tb/tb_system_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_system_tester
// Description : Self-checking bench for system_tester with a timeline-based model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_system_tester;

  localparam int S = 2;
  localparam int L = 8 * (S + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0, start_a = 1'b0, start_b = 1'b0;
  int   mode = 0;
  logic dut_out, v1, v2, v3, busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] vec_idx;
  logic dut_out_a, v1_a, v2_a, v3_a, busy_a, done_a, pass_a;
  logic [3:0] err_cnt_a;
  logic [2:0] vec_idx_a;
  logic dut_out_b, v1_b, v2_b, v3_b, busy_b, done_b, pass_b;
  logic [3:0] err_cnt_b;
  logic [2:0] vec_idx_b;

  // 0 correct NAND, 1 stuck-at-1, 2 stuck-at-0, 3 inverted
  function automatic logic checker_model(input int m, input logic [2:0] v);
    case (m)
      0:       return ~(v[2] & v[1] & v[0]);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return v[2] & v[1] & v[0];
    endcase
  endfunction

  assign dut_out   = checker_model(mode, {v1, v2, v3});
  assign dut_out_a = ~(v1_a & v2_a & v3_a);
  assign dut_out_b = ~(v1_b & v2_b & v3_b);

  system_tester #(.SETTLE_CYC(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .v1(v1), .v2(v2), .v3(v3), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .vec_idx(vec_idx)
  );
  system_tester #(.SETTLE_CYC(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a),
    .v1(v1_a), .v2(v2_a), .v3(v3_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_cnt_a), .vec_idx(vec_idx_a)
  );
  system_tester #(.SETTLE_CYC(15)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b),
    .v1(v1_b), .v2(v2_b), .v3(v3_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_cnt_b), .vec_idx(vec_idx_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // Model: mt counts edges since the accepting edge; vector k occupies
  // mt in [k*(S+1), (k+1)*(S+1)), done appears at mt==L, then idle.
  int   mt = -1;
  int   m_err = 0;
  logic m_pass = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mt = -1; m_err = 0; m_pass = 1'b0;
    end else if (mt < 0) begin
      if (start) begin mt = 0; m_err = 0; m_pass = 1'b0; end
    end else if (mt < L) begin
      mt = mt + 1;
      if (mt % (S + 1) == 0) begin
        if (checker_model(mode, 3'(mt / (S + 1) - 1)) != ((mt / (S + 1) - 1) != 7))
          m_err = m_err + 1;
      end
      if (mt == L) m_pass = (m_err == 0);
    end else begin
      mt = -1;
    end
  end

  int   seq[$];
  int   done_seen = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      automatic logic e_busy = (mt >= 0 && mt < L);
      automatic logic e_done = (mt == L);
      automatic int   e_vec  = e_busy ? mt / (S + 1) : 0;
      automatic int   e_v    = e_busy ? e_vec : 0;
      n_cmp++;
      if (busy !== e_busy || done !== e_done || pass !== m_pass ||
          int'(err_cnt) != m_err || int'({v1, v2, v3}) != e_v ||
          (e_busy && int'(vec_idx) != e_vec)) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t: got busy=%b done=%b pass=%b err=%0d v=%0d vec=%0d required busy=%b done=%b pass=%b err=%0d v=%0d vec=%0d",
                 $time, busy, done, pass, err_cnt, {v1, v2, v3}, vec_idx,
                 e_busy, e_done, m_pass, m_err, e_v, e_vec);
      end
      if (busy && (seq.size() == 0 || seq[$] != int'(vec_idx))) seq.push_back(int'(vec_idx));
      if (done) done_seen++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int which, input logic val);
    case (which)
      0:       start   = val;
      1:       start_a = val;
      default: start_b = val;
    endcase
  endtask

  task automatic pulse_start(input int which);
    @(posedge clk); #1 set_start(which, 1'b1);
    @(posedge clk); #1 set_start(which, 1'b0);
  endtask

  // Returns the cycle number (1 = cycle right after the accepting edge) holding done.
  task automatic wait_done(input int which, input int budget, output int cyc);
    logic d;
    cyc = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      d = (which == 0) ? done : (which == 1) ? done_a : done_b;
      if (d) begin cyc = n + 1; break; end
    end
  endtask

  task automatic run_main(input int m, input string tag, input int exp_err, input int exp_pass);
    int c;
    mode = m;
    seq.delete();
    pulse_start(0);
    wait_done(0, 200, c);
    chk({tag, "_done_cycle"}, c, 25);
    chk({tag, "_err_cnt"}, int'(err_cnt), exp_err);
    chk({tag, "_pass"}, int'(pass), exp_pass);
    repeat (4) @(posedge clk);
    #1 chk({tag, "_err_hold"}, int'(err_cnt), exp_err);
  endtask

  initial begin
    int c;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", int'({busy, done, pass, v1, v2, v3}), 0);
    chk("reset_err_vec", int'({err_cnt, vec_idx}), 0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_main(0, "good", 0, 1);
    chk("seq_len", seq.size(), 8);
    for (int i = 0; i < 8 && i < seq.size(); i++) chk("seq_order", seq[i], i);
    run_main(1, "stuck1", 1, 0);
    run_main(2, "stuck0", 7, 0);
    run_main(3, "inverted", 8, 0);

    // start held high across the whole run, including the DONE cycle
    mode = 0;
    done_seen = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    wait_done(0, 200, c);
    chk("held_done_cycle", c, 25);
    @(posedge clk); #1 start = 1'b0;
    chk("held_no_restart", int'(busy), 0);
    repeat (30) @(posedge clk);
    #1 chk("held_one_done", done_seen, 1);

    // reset in the middle of vector 4
    mode = 2;
    pulse_start(0);
    c = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (busy && vec_idx == 3'd4) begin c = 1; break; end
    end
    chk("reach_vec4", c, 1);
    chk("err_before_reset", int'(err_cnt), 4);
    done_seen = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", int'({busy, done, pass, v1, v2, v3}), 0);
    chk("midrun_reset_err_vec", int'({err_cnt, vec_idx}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("midrun_no_done", done_seen, 0);
    run_main(0, "after_reset", 0, 1);
    chk("after_reset_first_vec", (seq.size() > 0) ? seq[0] : -1, 0);

    // other settle lengths
    pulse_start(1);
    wait_done(1, 60, c);
    chk("settle1_done_cycle", c, 17);
    chk("settle1_pass_err", int'({pass_a, err_cnt_a}), 16);
    pulse_start(2);
    wait_done(2, 300, c);
    chk("settle15_done_cycle", c, 129);
    chk("settle15_pass_err", int'({pass_b, err_cnt_b}), 16);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
